voice_bank: RTL and testbench

- Polyphonic oscillator bank: decodes one-cycle note commands from the Avalon-side control register.
- Allocates up to NVOICES sawtooth voices and streams their samples time-multiplexed, one voice per enabled cycle.
- Sits between the control register and the mixer; the mixer accumulates NVOICES consecutive samples into one mixed sample.
- The rate divider and the sigma-delta DAC are separate blocks.

---
 rtl/synth_pkg.sv | 67 ++++++
 rtl/voice_osc.sv | 55 +++++
 rtl/voice_bank.sv | 80 ++++++++
 tb/tb_voice_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the voice bank: defaults, command encoding, the top-octave
// increment table and the note-to-(octave, semitone) split.
package synth_pkg;

    localparam int NVOICES_DEF = 10;
    localparam int CLK_HZ_DEF  = 50_000_000;
    localparam int PHASE_W_DEF = 32;
    localparam int SAMPLE_W    = 24;

    typedef enum logic [1:0] {
        CMD_IDLE   = 2'b00,
        CMD_ON     = 2'b01,
        CMD_OFF    = 2'b10,
        CMD_ALLOFF = 2'b11
    } cmd_e;

    typedef struct packed {
        logic [3:0] oct;
        logic [3:0] semi;
    } note_pos_t;

    // Phase increment for semitone s of octave 10 at a per-voice rate of clk_hz/nv.
    function automatic logic [31:0] calc_inc_top(input int s, input int clk_hz, input int nv);
        real ratio;
        case (s)
            1:       ratio = 1.0594630943592953;
            2:       ratio = 1.1224620483093730;
            3:       ratio = 1.1892071150027210;
            4:       ratio = 1.2599210498948732;
            5:       ratio = 1.3348398541700344;
            6:       ratio = 1.4142135623730951;
            7:       ratio = 1.4983070768766815;
            8:       ratio = 1.5874010519681994;
            9:       ratio = 1.6817928305074290;
            10:      ratio = 1.7817974362806785;
            11:      ratio = 1.8877486253633868;
            default: ratio = 1.0;
        endcase
        return 32'($rtoi(8372.018 * ratio * 4294967296.0 * real'(nv) / real'(clk_hz) + 0.5));
    endfunction

    localparam logic [31:0] INC_TOP [12] = '{
        calc_inc_top(0,  CLK_HZ_DEF, NVOICES_DEF), calc_inc_top(1,  CLK_HZ_DEF, NVOICES_DEF),
        calc_inc_top(2,  CLK_HZ_DEF, NVOICES_DEF), calc_inc_top(3,  CLK_HZ_DEF, NVOICES_DEF),
        calc_inc_top(4,  CLK_HZ_DEF, NVOICES_DEF), calc_inc_top(5,  CLK_HZ_DEF, NVOICES_DEF),
        calc_inc_top(6,  CLK_HZ_DEF, NVOICES_DEF), calc_inc_top(7,  CLK_HZ_DEF, NVOICES_DEF),
        calc_inc_top(8,  CLK_HZ_DEF, NVOICES_DEF), calc_inc_top(9,  CLK_HZ_DEF, NVOICES_DEF),
        calc_inc_top(10, CLK_HZ_DEF, NVOICES_DEF), calc_inc_top(11, CLK_HZ_DEF, NVOICES_DEF)
    };

    // Compare chain instead of a divider: octave = n/12, semitone = n mod 12.
    function automatic note_pos_t note_split(input logic [6:0] n);
        note_pos_t  r;
        logic [6:0] base;
        r.oct = 4'd0;
        base  = 7'd0;
        for (int k = 1; k <= 10; k++) begin
            if (n >= 7'(12 * k)) begin
                r.oct = 4'(k);
                base  = 7'(12 * k);
            end
        end
        r.semi = 4'(n - base);
        return r;
    endfunction

endpackage

// File: rtl/voice_osc.sv
// One sawtooth voice: active flag, note, increment and phase accumulator.
module voice_osc
    import synth_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_alloc,
    input  logic                i_retrig,
    input  logic                i_off,
    input  logic                i_step,
    input  logic [6:0]          i_note,
    input  logic [PHASE_W-1:0]  i_inc,
    output logic                o_active,
    output logic [6:0]          o_note,
    output logic [SAMPLE_W-1:0] o_sample
);

    logic               r_active;
    logic [6:0]         r_note;
    logic [PHASE_W-1:0] r_inc;
    logic [PHASE_W-1:0] r_phase;
    logic signed [19:0] w_s20;
    logic               w_unused_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_note   <= '0;
            r_inc    <= '0;
            r_phase  <= '0;
        end else if (i_alloc) begin
            r_active <= 1'b1;
            r_note   <= i_note;
            r_inc    <= i_inc;
            r_phase  <= '0;
        end else begin
            if (i_off)
                r_active <= 1'b0;
            // A retrigger overrides this cycle's phase step.
            if (i_retrig)
                r_phase <= '0;
            else if (i_step && r_active)
                r_phase <= r_phase + r_inc;
        end
    end

    assign w_s20       = {~r_phase[PHASE_W-1], r_phase[PHASE_W-2 -: 19]};
    assign w_unused_lo = &{1'b0, r_phase[PHASE_W-21:0]};
    assign o_active    = r_active;
    assign o_note      = r_note;
    assign o_sample    = r_active ? {{(SAMPLE_W-20){w_s20[19]}}, w_s20} : '0;

endmodule

// File: rtl/voice_bank.sv
// Polyphonic sawtooth bank: note command decode, voice allocation and a
// time-multiplexed sample stream, one voice slot per enabled cycle.
module voice_bank
    import synth_pkg::*;
#(
    parameter int NVOICES = NVOICES_DEF,
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic [15:0]                i_data,
    output logic signed [SAMPLE_W-1:0] o_signal
);

    localparam int SLOT_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;

    cmd_e                w_cmd;
    note_pos_t           w_pos;
    logic [6:0]          w_note_in;
    logic [PHASE_W-1:0]  w_inc;
    logic [31:0]         w_inc_tab [12];
    logic [NVOICES-1:0]  w_active, w_match, w_free, w_first;
    logic [NVOICES-1:0]  w_alloc, w_retrig, w_off;
    logic [6:0]          w_notes   [NVOICES];
    logic [SAMPLE_W-1:0] w_samples [NVOICES];
    logic                w_hit;
    logic                w_unused_bits;
    logic [SLOT_W-1:0]   r_slot;

    for (genvar gi = 0; gi < 12; gi++) begin : g_tab
        localparam logic [31:0] INC_G = (CLK_HZ == CLK_HZ_DEF && NVOICES == NVOICES_DEF)
                                      ? INC_TOP[gi] : calc_inc_top(gi, CLK_HZ, NVOICES);
        assign w_inc_tab[gi] = INC_G;
    end

    assign w_cmd         = cmd_e'(i_data[15:14]);
    assign w_note_in     = i_data[6:0];
    assign w_unused_bits = &{1'b0, i_data[13:7]};
    assign w_pos         = note_split(w_note_in);
    assign w_inc         = PHASE_W'(w_inc_tab[w_pos.semi] >> (4'd10 - w_pos.oct));

    // Lowest-index free voice as a one-hot vector.
    assign w_free  = ~w_active;
    assign w_first = w_free & (~w_free + NVOICES'(1));
    assign w_hit   = |w_match;

    for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice
        assign w_match[gi]  = w_active[gi] && (w_notes[gi] == w_note_in);
        assign w_retrig[gi] = (w_cmd == CMD_ON) && w_match[gi];
        assign w_alloc[gi]  = (w_cmd == CMD_ON) && !w_hit && w_first[gi];
        assign w_off[gi]    = (w_cmd == CMD_ALLOFF) || ((w_cmd == CMD_OFF) && w_match[gi]);

        voice_osc #(.PHASE_W(PHASE_W)) u_osc (
            .clk      (clk),
            .reset    (reset),
            .i_alloc  (w_alloc[gi]),
            .i_retrig (w_retrig[gi]),
            .i_off    (w_off[gi]),
            .i_step   (clk_en && (r_slot == SLOT_W'(gi))),
            .i_note   (w_note_in),
            .i_inc    (w_inc),
            .o_active (w_active[gi]),
            .o_note   (w_notes[gi]),
            .o_sample (w_samples[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot   <= '0;
            o_signal <= '0;
        end else if (clk_en) begin
            o_signal <= w_samples[r_slot];
            r_slot   <= (r_slot == SLOT_W'(NVOICES - 1)) ? '0 : r_slot + 1'b1;
        end
    end

endmodule

// File: tb/tb_voice_bank.sv
// Self-checking bench for voice_bank: fixed vector table, directed corner
// sequences and randomized commands against a behavioural voice model.
module tb_voice_bank;

    localparam int NV = 10;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clk_en = 1'b0;
    logic [15:0]        i_data = 16'h0000;
    logic signed [23:0] o_signal;

    int n_tests = 0;
    int n_fail  = 0;

    voice_bank dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .i_data   (i_data),
        .o_signal (o_signal)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    bit          m_active [NV];
    int          m_note   [NV];
    int unsigned m_inc    [NV];
    int unsigned m_phase  [NV];
    int          m_slot;
    int          m_sig;

    function automatic int unsigned ref_inc(input int n);
        real top;
        top = $floor(8372.018 * $pow(2.0, real'(n % 12) / 12.0) * 4294967296.0
                     / (50.0e6 / 10.0) + 0.5);
        return int'(longint'(top)) >> (10 - n / 12);
    endfunction

    function automatic int ref_sample(input int v);
        if (!m_active[v]) return 0;
        return int'(m_phase[v] >> 12) - 524288;
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic [15:0] d);
        int n, hit, free;
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                m_active[v] = 0; m_note[v] = 0; m_inc[v] = 0; m_phase[v] = 0;
            end
            m_slot = 0;
            m_sig  = 0;
            return;
        end
        if (en) begin
            m_sig = ref_sample(m_slot);
            if (m_active[m_slot]) m_phase[m_slot] = m_phase[m_slot] + m_inc[m_slot];
            m_slot = (m_slot + 1) % NV;
        end
        n = int'(d[6:0]);
        hit = -1;
        for (int v = 0; v < NV; v++) if (m_active[v] && m_note[v] == n) hit = v;
        case (d[15:14])
            2'b01: begin
                if (hit >= 0) m_phase[hit] = 0;
                else begin
                    free = -1;
                    for (int v = NV - 1; v >= 0; v--) if (!m_active[v]) free = v;
                    if (free >= 0) begin
                        m_active[free] = 1; m_note[free] = n;
                        m_phase[free] = 0;  m_inc[free] = ref_inc(n);
                    end
                end
            end
            2'b10: if (hit >= 0) m_active[hit] = 0;
            2'b11: for (int v = 0; v < NV; v++) m_active[v] = 0;
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, check outputs 1 time unit later.
    task automatic tick(input logic rst, input logic en, input logic [15:0] d);
        reset = rst; clk_en = en; i_data = d;
        @(posedge clk);
        model_step(rst, en, d);
        #1;
        chk("signal", int'(o_signal), m_sig);
        chk("slot", int'(dut.r_slot), m_slot);
        $display("[TB] rst=%0b en=%0b data=%04h sig=%0d slot=%0d", rst, en, d, o_signal, dut.r_slot);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 16'h0000);
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] data;
        int          exp;
    } vec_t;

    vec_t vecs [22];

    initial begin
        // Note 120 on voice 0: first sample -2^19, one round later -2^19 + (inc>>12).
        for (int i = 0; i < 22; i++) vecs[i] = '{1'b0, 1'b1, 16'h0000, 0};
        vecs[0]  = '{1'b1, 1'b1, 16'h0000, 0};
        vecs[1]  = '{1'b0, 1'b1, 16'h4078, 0};
        vecs[11].exp = -524288;
        vecs[21].exp = -522533;

        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].data);
            chk($sformatf("vec%0d", i), int'(o_signal), vecs[i].exp);
        end

        // Silence after reset: 30 cycles of zeros, slot wraps.
        tick(1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b1, 16'h0000);
            chk("silent", int'(o_signal), 0);
        end
        chk("slot_wrap", int'(dut.r_slot), 0);

        // n=120 on voice 0, n=108 on voice 1 (half increment), four rounds.
        tick(1'b0, 1'b1, 16'h4078);
        tick(1'b0, 1'b1, 16'h406C);
        chk("inc108", int'(ref_inc(108)), 7191509 / 2);
        idle(4 * NV);

        // Fill all voices, 11th dropped, free voice 3 and re-allocate it.
        tick(1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 11; i++) tick(1'b0, 1'b1, 16'h4000 | 16'(60 + i));
        idle(NV);
        tick(1'b0, 1'b1, 16'h8000 | 16'd63);
        tick(1'b0, 1'b1, 16'h4000 | 16'd100);
        chk("realloc3", m_note[3], 100);
        idle(2 * NV);

        // Retrigger an active note after 5 rounds, then all-notes-off.
        tick(1'b0, 1'b1, 16'h4000 | 16'd65);
        idle(5 * NV);
        tick(1'b0, 1'b1, 16'h4000 | 16'd65);
        idle(NV + 3);
        tick(1'b0, 1'b1, 16'hC000);
        for (int i = 0; i < 2 * NV; i++) begin
            tick(1'b0, 1'b1, 16'h0000);
            if (i >= NV) chk("alloff", int'(o_signal), 0);
        end

        // clk_en low for 7 cycles with a note-on in the middle, then reset mid-round.
        tick(1'b0, 1'b1, 16'h4000 | 16'd72);
        idle(NV + 4);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h4000 | 16'd84);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        idle(2 * NV);
        tick(1'b1, 1'b0, 16'h4000 | 16'd90);
        chk("rst_sig", int'(o_signal), 0);
        chk("rst_slot", int'(dut.r_slot), 0);
        idle(NV);

        // Randomized commands against the model.
        for (int i = 0; i < 2000; i++) begin
            logic        r_rst, r_en;
            logic [15:0] r_d;
            int          pick;
            r_rst = ($urandom_range(199) == 0);
            r_en  = ($urandom_range(9) < 8);
            pick  = $urandom_range(99);
            r_d   = 16'($urandom);
            if (pick < 70)      r_d = 16'h0000;
            else if (pick < 85) r_d[15:14] = 2'b01;
            else if (pick < 97) r_d[15:14] = 2'b10;
            else                r_d[15:14] = 2'b11;
            if (r_d[15:14] != 2'b00 && $urandom_range(3) != 0)
                r_d[6:0] = 7'(60 + $urandom_range(13));
            tick(r_rst, r_en, r_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
